// File: rtl/fetch_pred.sv
// Instruction fetch stage: sequential PC stream, predecode redirect on direct jumps
// and predicted-taken branches, 2-bit counter table trained by execute resolution.
module fetch_pred #(
    parameter int          IDX_W    = 8,
    parameter logic [13:0] RESET_PC = 14'h0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stall,
    output logic [13:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_data,
    output logic        f_valid,
    output logic [31:0] f_inst,
    output logic [13:0] f_pc,
    output logic        f_pred,
    input  logic        b_is_hazard,
    input  logic [13:0] b_addr,
    input  logic        b_is_b_ope,
    input  logic        b_is_branch,
    input  logic [13:0] b_w_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);
    localparam int DEPTH = 1 << IDX_W;

    logic [13:0]      pc_q;
    logic [13:0]      rpc;
    logic             rv;
    logic [1:0]       ctr [DEPTH];
    logic [31:0]      br_q;
    logic [31:0]      miss_q;

    logic [5:0]       ope;
    logic [13:0]      target;
    logic [IDX_W-1:0] ridx;
    logic [IDX_W-1:0] widx;
    logic             jump;
    logic             cbr;
    logic             taken_p;
    logic             unused_wpc;

    assign ope        = imem_data[31:26];
    assign target     = imem_data[13:0];
    assign ridx       = rpc[IDX_W-1:0];
    assign widx       = b_w_pc[IDX_W-1:0];
    assign unused_wpc = ^b_w_pc;

    assign jump    = (ope == 6'b000010) || (ope == 6'b000110);
    assign cbr     = (ope[1:0] == 2'b10) && (ope[5:4] != 2'b00);
    // Lookup reads the pre-update counter even when training hits the same index.
    assign taken_p = rv & (jump | (cbr & ctr[ridx][1]));

    assign imem_addr = pc_q;
    assign imem_en   = ~stall;
    assign f_valid   = rv & ~b_is_hazard;
    assign f_inst    = imem_data;
    assign f_pc      = rpc;
    assign f_pred    = taken_p;
    assign br_cnt    = br_q;
    assign miss_cnt  = miss_q;

    // Hazard outranks stall so a mispredict is never delayed by backpressure.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc_q <= RESET_PC;
            rpc  <= RESET_PC;
            rv   <= 1'b0;
        end else if (b_is_hazard) begin
            pc_q <= b_addr;
            rv   <= 1'b0;
        end else if (stall) begin
            pc_q <= pc_q;
            rv   <= rv;
        end else if (taken_p) begin
            pc_q <= target;
            rv   <= 1'b0;
        end else begin
            rpc  <= pc_q;
            pc_q <= pc_q + 14'd1;
            rv   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr[IDX_W'(i)] <= 2'b01;
            end
        end else if (b_is_b_ope) begin
            if (b_is_branch) begin
                if (ctr[widx] != 2'b11) begin
                    ctr[widx] <= ctr[widx] + 2'd1;
                end
            end else if (ctr[widx] != 2'b00) begin
                ctr[widx] <= ctr[widx] - 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            br_q   <= 32'd0;
            miss_q <= 32'd0;
        end else begin
            br_q   <= br_q + {31'd0, b_is_b_ope};
            miss_q <= miss_q + {31'd0, b_is_b_ope & b_is_hazard};
        end
    end
endmodule

// File: tb/tb_fetch_pred.sv
// Self-checking bench for fetch_pred: directed vector table, hand-written predictor
// and wrap sequences, then random stimulus against an arithmetic reference model.
module tb_fetch_pred;
    localparam int TBL = 256;

    logic        clk = 1'b0;
    logic        rstn, stall, b_is_hazard, b_is_b_ope, b_is_branch;
    logic [13:0] b_addr, b_w_pc, imem_addr, f_pc;
    logic        imem_en, f_valid, f_pred;
    logic [31:0] imem_data, f_inst, br_cnt, miss_cnt;
    logic [31:0] mem [0:16383];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        stall;
        logic        haz;
        logic [13:0] baddr;
        logic        bop;
        logic        bbr;
        logic [13:0] bwpc;
        logic [13:0] exp_addr;
        logic        exp_valid;
        logic [13:0] exp_pc;
        logic        exp_pred;
        logic [31:0] exp_br;
        logic [31:0] exp_miss;
    } vec_t;

    vec_t vecs [15];

    always #5 clk = ~clk;

    fetch_pred #(.IDX_W(8), .RESET_PC(14'h0000)) dut (
        .clk(clk), .rstn(rstn), .stall(stall),
        .imem_addr(imem_addr), .imem_en(imem_en), .imem_data(imem_data),
        .f_valid(f_valid), .f_inst(f_inst), .f_pc(f_pc), .f_pred(f_pred),
        .b_is_hazard(b_is_hazard), .b_addr(b_addr), .b_is_b_ope(b_is_b_ope),
        .b_is_branch(b_is_branch), .b_w_pc(b_w_pc),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    // Synchronous-read instruction memory: data one cycle after an enabled address.
    always @(posedge clk) begin
        if (imem_en) imem_data <= mem[imem_addr];
    end

    function automatic vec_t mk(logic s, logic h, logic [13:0] ba, logic o, logic bb,
                                logic [13:0] wp, logic [13:0] ea, logic ev,
                                logic [13:0] ep, logic epr, logic [31:0] ebr,
                                logic [31:0] em);
        vec_t v;
        v.stall = s; v.haz = h; v.baddr = ba; v.bop = o; v.bbr = bb; v.bwpc = wp;
        v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_pred = epr;
        v.exp_br = ebr; v.exp_miss = em;
        return v;
    endfunction

    task automatic applyStimulus(input logic r, input logic s, input logic h,
                                 input logic [13:0] ba, input logic o, input logic bb,
                                 input logic [13:0] wp);
        @(negedge clk);
        rstn = r; stall = s; b_is_hazard = h; b_addr = ba;
        b_is_b_ope = o; b_is_branch = bb; b_w_pc = wp;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
    endtask

    task automatic trainPulse(input logic taken);
        applyStimulus(1'b1, 1'b0, 1'b0, 14'h0, 1'b1, taken, 14'h010);
    endtask

    // Steer fetch to the branch at 0x010 and look at its prediction and follow-up.
    task automatic observeBranch(input logic exp_pred, input string tag);
        applyStimulus(1'b1, 1'b0, 1'b1, 14'h010, 1'b0, 1'b0, 14'h0);
        checkOutput({tag, " hazard f_valid"}, 32'(f_valid), 32'd0);
        idle(1);
        checkOutput({tag, " bubble f_valid"}, 32'(f_valid), 32'd0);
        idle(1);
        checkOutput({tag, " f_valid"}, 32'(f_valid), 32'd1);
        checkOutput({tag, " f_pc"}, 32'(f_pc), 32'h010);
        checkOutput({tag, " f_pred"}, 32'(f_pred), 32'(exp_pred));
        idle(1);
        if (exp_pred) begin
            checkOutput({tag, " redirect bubble"}, 32'(f_valid), 32'd0);
            idle(1);
            checkOutput({tag, " target f_valid"}, 32'(f_valid), 32'd1);
            checkOutput({tag, " target f_pc"}, 32'(f_pc), 32'h080);
        end else begin
            checkOutput({tag, " fallthrough f_valid"}, 32'(f_valid), 32'd1);
            checkOutput({tag, " fallthrough f_pc"}, 32'(f_pc), 32'h011);
        end
    endtask

    logic [13:0] m_pc, m_rpc;
    bit          m_rv;
    int          m_ctr [TBL];
    logic [31:0] m_br, m_miss;

    task automatic modelReset();
        m_pc = 14'h0; m_rv = 1'b0; m_br = 0; m_miss = 0;
        for (int k = 0; k < TBL; k++) m_ctr[k] = 1;
    endtask

    initial begin
        logic r, s, h, o, bb;
        logic [13:0] ba, wp;
        logic [31:0] inst;
        int ope, idx;
        bit jump, cbr, taken;

        rstn = 1'b0; stall = 1'b0; b_is_hazard = 1'b0; b_addr = 14'h0;
        b_is_b_ope = 1'b0; b_is_branch = 1'b0; b_w_pc = 14'h0;

        for (int i = 0; i < 16384; i++) mem[i] = 32'(i);
        mem[14'h003] = 32'h0800_0040;
        mem[14'h043] = 32'h0800_0200;
        mem[14'h010] = 32'h4800_0080;

        vecs[0]  = mk(0,0,14'h000,0,0,14'h000, 14'h000,0,14'h000,0, 0,0);
        vecs[1]  = mk(0,0,14'h000,0,0,14'h000, 14'h001,1,14'h000,0, 0,0);
        vecs[2]  = mk(0,0,14'h000,0,0,14'h000, 14'h002,1,14'h001,0, 0,0);
        vecs[3]  = mk(0,0,14'h000,0,0,14'h000, 14'h003,1,14'h002,0, 0,0);
        vecs[4]  = mk(0,0,14'h000,0,0,14'h000, 14'h004,1,14'h003,1, 0,0);
        vecs[5]  = mk(0,0,14'h000,0,0,14'h000, 14'h040,0,14'h000,0, 0,0);
        vecs[6]  = mk(0,0,14'h000,0,0,14'h000, 14'h041,1,14'h040,0, 0,0);
        vecs[7]  = mk(1,0,14'h000,0,0,14'h000, 14'h042,1,14'h041,0, 0,0);
        vecs[8]  = mk(1,0,14'h000,0,0,14'h000, 14'h042,1,14'h041,0, 0,0);
        vecs[9]  = mk(1,0,14'h000,0,0,14'h000, 14'h042,1,14'h041,0, 0,0);
        vecs[10] = mk(0,0,14'h000,0,0,14'h000, 14'h042,1,14'h041,0, 0,0);
        vecs[11] = mk(0,0,14'h000,0,0,14'h000, 14'h043,1,14'h042,0, 0,0);
        vecs[12] = mk(1,1,14'h123,1,0,14'h020, 14'h044,0,14'h000,0, 0,0);
        vecs[13] = mk(0,0,14'h000,0,0,14'h000, 14'h123,0,14'h000,0, 1,1);
        vecs[14] = mk(0,0,14'h000,0,0,14'h000, 14'h124,1,14'h123,0, 1,1);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
            checkOutput("reset imem_addr", 32'(imem_addr), 32'h0);
            checkOutput("reset imem_en", 32'(imem_en), 32'd1);
            checkOutput("reset f_valid", 32'(f_valid), 32'd0);
            checkOutput("reset f_pred", 32'(f_pred), 32'd0);
            checkOutput("reset br_cnt", br_cnt, 32'd0);
            checkOutput("reset miss_cnt", miss_cnt, 32'd0);
        end

        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, vecs[i].stall, vecs[i].haz, vecs[i].baddr,
                          vecs[i].bop, vecs[i].bbr, vecs[i].bwpc);
            checkOutput($sformatf("vec%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("vec%0d imem_en", i), 32'(imem_en), 32'(!vecs[i].stall));
            checkOutput($sformatf("vec%0d f_valid", i), 32'(f_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d f_pc", i), 32'(f_pc), 32'(vecs[i].exp_pc));
                checkOutput($sformatf("vec%0d f_pred", i), 32'(f_pred), 32'(vecs[i].exp_pred));
                checkOutput($sformatf("vec%0d f_inst", i), f_inst, mem[vecs[i].exp_pc]);
            end
            checkOutput($sformatf("vec%0d br_cnt", i), br_cnt, vecs[i].exp_br);
            checkOutput($sformatf("vec%0d miss_cnt", i), miss_cnt, vecs[i].exp_miss);
        end

        // Predictor training and saturation on the branch at 0x010.
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
        idle(1);
        observeBranch(1'b0, "ctr init");
        trainPulse(1'b1); trainPulse(1'b1);
        observeBranch(1'b1, "ctr 11");
        trainPulse(1'b1); trainPulse(1'b1); trainPulse(1'b1);
        trainPulse(1'b0);
        observeBranch(1'b1, "ctr ceiling");
        trainPulse(1'b0);
        observeBranch(1'b0, "ctr 01");
        trainPulse(1'b0); trainPulse(1'b0); trainPulse(1'b0);
        trainPulse(1'b1);
        observeBranch(1'b0, "ctr floor");

        // Sequential wrap from 0x3FFF to 0x0000 without a bubble.
        applyStimulus(1'b1, 1'b0, 1'b1, 14'h3FFD, 1'b0, 1'b0, 14'h0);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrap%0d f_valid", i), 32'(f_valid), 32'd1);
            checkOutput($sformatf("wrap%0d f_pc", i), 32'(f_pc), 32'(14'(14'h3FFD + i)));
            idle(1);
        end

        // Randomized program and resolution traffic against the reference model.
        for (int i = 0; i < 16384; i++) begin
            case ($urandom_range(0, 9))
                0:       mem[i] = {6'b000010, 26'($urandom)};
                1:       mem[i] = {6'b000110, 26'($urandom)};
                2, 3:    mem[i] = {2'($urandom_range(1, 3)), 2'($urandom), 2'b10, 26'($urandom)};
                default: mem[i] = $urandom;
            endcase
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0, 14'h0);
        modelReset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            r  = ($urandom_range(0, 399) != 0);
            s  = ($urandom_range(0, 5) == 0);
            h  = ($urandom_range(0, 11) == 0);
            ba = 14'($urandom);
            o  = ($urandom_range(0, 2) == 0);
            bb = 1'($urandom_range(0, 1));
            wp = m_rv ? m_rpc : 14'($urandom);
            if ($urandom_range(0, 1) == 0) wp = 14'($urandom);
            applyStimulus(r, s, h, ba, o, bb, wp);

            inst  = mem[m_rpc];
            ope   = int'(inst[31:26]);
            jump  = (ope == 2) || (ope == 6);
            cbr   = (ope % 4 == 2) && (ope / 16 != 0);
            taken = m_rv && (jump || (cbr && m_ctr[m_rpc % TBL] >= 2));

            checkOutput("rnd imem_addr", 32'(imem_addr), 32'(m_pc));
            checkOutput("rnd imem_en", 32'(imem_en), 32'(!s));
            checkOutput("rnd f_valid", 32'(f_valid), 32'(m_rv && !h));
            if (m_rv && !h) begin
                checkOutput("rnd f_pc", 32'(f_pc), 32'(m_rpc));
                checkOutput("rnd f_inst", f_inst, inst);
                checkOutput("rnd f_pred", 32'(f_pred), 32'(taken));
            end
            checkOutput("rnd br_cnt", br_cnt, m_br);
            checkOutput("rnd miss_cnt", miss_cnt, m_miss);

            if (!r) begin
                modelReset();
            end else begin
                if (o) begin
                    m_br++;
                    if (h) m_miss++;
                    idx = wp % TBL;
                    if (bb) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
                    else    m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
                end
                if (h) begin
                    m_pc = ba; m_rv = 1'b0;
                end else if (!s) begin
                    if (taken) begin
                        m_pc = 14'(inst[15:0] % 16384); m_rv = 1'b0;
                    end else begin
                        m_rpc = m_pc; m_pc = m_pc + 14'd1; m_rv = 1'b1;
                    end
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fetch_pred.md
# fetch_pred

Instruction fetch stage with a 2-bit branch predictor. It generates the instruction-memory address stream, predecodes returned instructions to redirect on direct jumps and predicted-taken branches, and delivers instructions with their PC and prediction bit to decode. The prediction bit becomes ctrl[0] (was_branch) at execute. It consumes the execute unit's registered branch-resolution outputs (b_is_hazard, b_addr, b_is_b_ope, b_is_branch, b_w_pc) to recover from mispredicts and to train the counter table.

## Interface
- IDX_W, 8, predictor index width; the table holds 2^IDX_W counters.
- RESET_PC, 14'h0000, first fetch address after reset.
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  reset, synchronous, active-low.
- stall  in  1  downstream not accepting; freeze fetch.
- imem_addr  out  14  instruction memory address (equals pc_q).
- imem_en  out  1  memory read enable (= ~stall); data appears one cycle after the enabled address.
- imem_data  in  32  instruction word; ope = [31:26], imm = [15:0].
- f_valid  out  1  f_inst/f_pc/f_pred are valid.
- f_inst  out  32  instruction (= imem_data).
- f_pc  out  14  PC of f_inst.
- f_pred  out  1  predicted taken (or direct jump).
- b_is_hazard, b_addr[13:0], b_is_b_ope, b_is_branch, b_w_pc[13:0]  in  execute resolution; each value is valid for one cycle.
- br_cnt  out  32  count of resolved conditional branches.
- miss_cnt  out  32  count of mispredicted conditional branches.

## Operation
- State: pc_q (14), rv (response valid), rpc (14; PC of the data on imem_data), ctr[2^IDX_W] (2-bit), br_cnt, miss_cnt.
- Predecode when rv=1:
  - jump = ope is 000010 (J) or 000110 (JAL).
  - cbr = ope[1:0]==10 and ope[5:4]!=00.
  - taken_p = jump or (cbr and ctr[rpc[IDX_W-1:0]][1]).
  - target = imm[13:0].
- f_valid = rv & ~b_is_hazard. f_pc = rpc. f_pred = taken_p.
- Next-state priority, highest first:
  - ~rstn: pc_q<=RESET_PC, rv<=0, every ctr<=2'b01, both perf counters<=0.
  - b_is_hazard: pc_q<=b_addr, rv<=0. This overrides stall and predecode; the instruction currently on the output is squashed.
  - stall: pc_q, rv, rpc hold.
  - rv & taken_p: pc_q<=target, rv<=0. The sequential fetch issued this cycle is wrong-path and is dropped.
  - otherwise: rpc<=pc_q, pc_q<=pc_q+1 (14-bit wrap, 3FFF->0000), rv<=1.
- Training: runs regardless of stall.
  - When b_is_b_ope=1, ctr[b_w_pc[IDX_W-1:0]] saturating-increments if b_is_branch, else saturating-decrements (00 floor, 11 ceiling).
  - A same-cycle lookup of the same index sees the old value.
- Perf counters:
  - br_cnt += b_is_b_ope.
  - miss_cnt += b_is_b_ope & b_is_hazard.
  - Both wrap modulo 2^32.
- JR, JALR and conditional branches are never redirected here except via prediction; their correction always arrives through b_is_hazard.

## Timing
- Reset values: imem_addr=RESET_PC, f_valid=0, f_pred=0 (rv=0), br_cnt=miss_cnt=0.
- imem_en=1 while stall=0 during reset.
- First release cycle after rstn goes high: imem_addr=RESET_PC, f_valid=0.
- Next cycle: f_valid=1, f_pc=RESET_PC.
- Sequential throughput: 1 instruction/cycle.
- Predicted-taken or jump: 1 bubble cycle (f_valid=0), then f_pc=target.
- Hazard: f_valid=0 in the hazard cycle and the next; f_pc=b_addr on the second cycle after the hazard.
- Stall: outputs are stable for the whole stall. Memory holds its data because imem_en=0.
- Hazard during stall: the redirect is taken immediately and the stall does not delay it.
- Reset mid-operation: all in-flight state is discarded and the predictor is reinitialised.

## Test plan
- Reset, then release: imem_addr 0,1,2…; f_valid rises on the second cycle with f_pc=0, f_pred=0; all counters=01.
- Stall held 3 cycles while f_pc=5: f_pc stays 5, imem_addr stays 6, imem_en=0; fetch resumes at f_pc=6.
- J at PC 3 with imm=0x0040: f_pred=1 at f_pc=3, next cycle f_valid=0, then f_pc=0x0040.
- Two b_is_b_ope pulses with b_is_branch=1, b_w_pc=0x010: counter 01->11. Branch at PC 0x010 then shows f_pred=1 and redirects to its imm. Three more taken updates leave the counter at 11; four not-taken updates reach 00.
- Cycle with b_is_hazard=1, b_addr=0x123, stall=1, and a J on the output: f_valid=0, next imem_addr=0x123. With b_is_b_ope=1, br_cnt and miss_cnt each +1.
- Sequential run through PC 0x3FFF: next f_pc=0x0000 with no bubble.
